// File: rtl/seq_divider_32_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the datapath width, the iteration count with its counter width, and
// the controller state encoding.
package seq_divider_32_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

endpackage

// File: rtl/seq_divider_32_div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem_i / rem_o : partial remainder before / after the step
//   dvd_i / dvd_o : remaining dividend bits, MSB consumed first
//   dvs_i         : divisor
//   quo_i / quo_o : quotient being built, new bit enters at the LSB
module div_step
  import seq_divider_32_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvd_i,
  input  logic [W-1:0] dvs_i,
  input  logic [W-1:0] quo_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dvd_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_i < dvs_i always holds, so the shifted value stays below 2*divisor
  // and the top bit of the W+1-bit difference is a reliable sign.
  always_comb begin
    shifted = {rem_i, dvd_i[W-1]};
    diff    = shifted - {1'b0, dvs_i};
    dvd_o   = {dvd_i[W-2:0], 1'b0};
    if (!diff[W]) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider_32.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a division (ignored while busy)
//   dividend, divisor   : operands, captured on an accepted start
//   Q, R                : quotient / remainder, held until the next start
//   done                : one-cycle pulse when Q/R are valid
//   busy                : high while iterating
//   div_by_zero         : set with done when the divisor was zero
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             accept;
  logic [WIDTH-1:0] step_rem, step_dvd, step_quo;

  assign accept = start && (state_q != ITER);

  div_step #(.W(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .quo_i (quo_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A zero divisor spends a single ITER cycle so done still lands one edge
  // after the accepting edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (dvs_q == '0 || cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? ITER : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ITER);
    done = (state_q == DONE);
  end

  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (accept) begin
      dvd_d = dividend;
      dvs_d = divisor;
      rem_d = '0;
      quo_d = '0;
      cnt_d = '0;
      dbz_d = 1'b0;
    end else if (state_q == ITER) begin
      if (dvs_q == '0) begin
        quo_d = '1;
        rem_d = dvd_q;
        dbz_d = 1'b1;
      end else begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

  assign Q           = quo_q;
  assign R           = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Self-checking bench for seq_divider_32: expected results are queued when a
// start is accepted and compared (value and arrival cycle) when done pulses.
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] Q;
  logic [31:0] R;
  logic        done;
  logic        busy;
  logic        div_by_zero;

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .Q           (Q),
    .R           (R),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge; returns 1ns after the accepting posedge.
  task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    e.name = name;
    e.q    = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r    = (b == 0) ? a : a % b;
    e.dbz  = (b == 0);
    e.due  = cyc + ((b == 0) ? 1 : 32);
    sb.push_back(e);
    check_eq({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check_eq("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq({e.name, "_Q"}, Q, e.q);
        check_eq({e.name, "_R"}, R, e.r);
        check_eq({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        check_eq({e.name, "_cycle"}, cyc, e.due);
      end
    end
  end

  initial begin
    logic seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_Q", Q, 32'd0);
    check_eq("rst_R", R, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    start_op("basic", 32'd100, 32'd7);
    wait_drain(40);
    repeat (3) @(negedge clk);
    check_eq("hold_Q", Q, 32'd14);
    check_eq("hold_R", R, 32'd2);
    check_eq("idle_busy", 32'(busy), 32'd0);

    @(negedge clk);
    start_op("dbz", 32'h1234_5678, 32'd0);
    wait_drain(40);

    @(negedge clk);
    start_op("max_by_1", 32'hFFFF_FFFF, 32'd1);
    wait_drain(40);
    @(negedge clk);
    start_op("small", 32'd5, 32'd9);
    wait_drain(40);

    // Start during ITER must be ignored; start held in DONE chains directly.
    @(negedge clk);
    start_op("busy_a", 32'd1234567, 32'd89);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1;
    divisor  = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("ignored_busy", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("busy_a_seen", 32'(seen), 32'd1);
    start_op("b2b", 32'd1000, 32'd10);
    wait_drain(40);

    // Reset mid-iteration: no done, outputs cleared, restart right away.
    @(negedge clk);
    start_op("aborted", 32'hDEAD_BEEF, 32'd3);
    sb.delete(sb.size() - 1);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_Q", Q, 32'd0);
    check_eq("abort_R", R, 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op("after_rst", 32'd81, 32'd9);
    wait_drain(40);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_op("rand", $urandom, (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom);
      wait_drain(40);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
